// File: rtl/long_op_scoreboard.sv
// Decode-stage scoreboard for in-flight long-latency ops (loads, mul/div): raises stall_id on RAW/WAW/structural hazards.
// Optional macro SB_COMPLETE_BYPASS_EN lets a same-cycle completion count as already cleared for all hazard checks.
module long_op_scoreboard #(
    parameter int MAX_OUT = 4,
    parameter int CNT_W   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    input  logic             issue_long,
    input  logic             issue_regwrite,
    input  logic [4:0]       issue_rd,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             rs1_used,
    input  logic             rs2_used,
    input  logic             flush,
    input  logic             complete_valid,
    input  logic [4:0]       complete_rd,
    output logic             stall_id,
    output logic             issue_fire,
    output logic [31:0]      pending_vec,
    output logic [CNT_W-1:0] outstanding
    ,
    output logic             sb_err
);
    logic [31:1]      pending;
    logic [CNT_W-1:0] cnt;
    logic             err;

    logic [31:0] pvec, clr_mask, set_mask, clr_now, live;
    logic        clr_ok, set_en, slot_free;
    logic        raw_hz, waw_hz, str_hz;

    // x0 is never pending, so pvec[0] = 0 makes every x0 lookup hazard-free
    assign pvec   = {pending, 1'b0};
    assign clr_ok = complete_valid & (complete_rd != 5'd0) & pvec[complete_rd];

    assign clr_mask = clr_ok ? (32'd1 << complete_rd) : 32'd0;
    assign set_mask = set_en ? (32'd1 << issue_rd)    : 32'd0;

`ifdef SB_COMPLETE_BYPASS_EN
    assign clr_now   = clr_mask;
    assign slot_free = complete_valid & pvec[complete_rd];
`else
    assign clr_now   = 32'd0;
    assign slot_free = 1'b0;
`endif

    assign live   = pvec & ~clr_now;
    assign raw_hz = (rs1_used & live[rs1_id]) | (rs2_used & live[rs2_id]);
    assign waw_hz = issue_regwrite & live[issue_rd];
    assign str_hz = issue_long & (cnt == CNT_W'(MAX_OUT)) & ~slot_free;

    // Gated by rst_n so every output reads 0 while reset is held
    assign stall_id   = rst_n & issue_valid & ~flush & (raw_hz | waw_hz | str_hz);
    assign issue_fire = rst_n & issue_valid & ~flush & ~stall_id;
    assign set_en     = issue_fire & issue_long & issue_regwrite & (issue_rd != 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            cnt     <= '0;
            err     <= 1'b0;
        end else begin
            // Clear before set: a same-register set+clear leaves the bit at 1
            pending <= ((pvec & ~clr_mask) | set_mask) >> 1;
            cnt     <= cnt + CNT_W'(set_en) - CNT_W'(clr_ok);
            err     <= err | (complete_valid & ~clr_ok);
        end
    end

    assign pending_vec = pvec;
    assign outstanding = cnt;
    assign sb_err      = err;
endmodule

// File: tb/tb_long_op_scoreboard.sv
// Self-checking bench for long_op_scoreboard: directed scenarios plus $urandom traffic against a register-set model.
module tb_long_op_scoreboard;
    localparam int MAX_OUT = 4;
    localparam int CNT_W   = 3;
`ifdef SB_COMPLETE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic issue_valid, issue_long, issue_regwrite, rs1_used, rs2_used, flush, complete_valid;
    logic [4:0] issue_rd, rs1_id, rs2_id, complete_rd;
    logic stall_id, issue_fire, sb_err;
    logic [31:0] pending_vec;
    logic [CNT_W-1:0] outstanding;

    always #5 clk = ~clk;

    long_op_scoreboard #(.MAX_OUT(MAX_OUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_long(issue_long), .issue_regwrite(issue_regwrite),
        .issue_rd(issue_rd), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_used(rs1_used), .rs2_used(rs2_used), .flush(flush),
        .complete_valid(complete_valid), .complete_rd(complete_rd),
        .stall_id(stall_id), .issue_fire(issue_fire), .pending_vec(pending_vec),
        .outstanding(outstanding), .sb_err(sb_err)
    );

    // Model: set of registers awaiting a result, plus sticky error flag
    bit m_pend [32];
    bit m_err;
    int n_chk = 0;
    int n_fail = 0;

    function automatic int m_count();
        int c = 0;
        for (int i = 1; i < 32; i++) if (m_pend[i]) c++;
        return c;
    endfunction

    function automatic logic [31:0] m_vec();
        logic [31:0] v = '0;
        for (int i = 1; i < 32; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        m_err = 1'b0;
    endtask

    // One cycle: drive inputs, check comb + state, clock, update model
    task automatic step(input string tag, input bit iv, input bit il, input bit rw, input logic [4:0] rd,
                        input logic [4:0] r1, input bit u1, input logic [4:0] r2, input bit u2,
                        input bit fl, input bit cv, input logic [4:0] cr);
        bit busy1, busy2, busyd, room, exp_stall, exp_fire, cleared_ok;
        issue_valid = iv; issue_long = il; issue_regwrite = rw; issue_rd = rd;
        rs1_id = r1; rs1_used = u1; rs2_id = r2; rs2_used = u2;
        flush = fl; complete_valid = cv; complete_rd = cr;
        #3;
        // A register is "still busy" if pending and not retiring right now under bypass
        cleared_ok = cv && cr != 0 && m_pend[cr];
        busy1 = u1 && r1 != 0 && m_pend[r1] && !(BYP && cleared_ok && cr == r1);
        busy2 = u2 && r2 != 0 && m_pend[r2] && !(BYP && cleared_ok && cr == r2);
        busyd = rw && rd != 0 && m_pend[rd] && !(BYP && cleared_ok && cr == rd);
        room  = (m_count() < MAX_OUT) || (BYP && cv && m_pend[cr]);
        exp_stall = iv && !fl && (busy1 || busy2 || busyd || (il && !room));
        exp_fire  = iv && !fl && !exp_stall;
        chk({tag, ".stall"}, 32'(stall_id), 32'(exp_stall));
        chk({tag, ".fire"},  32'(issue_fire), 32'(exp_fire));
        @(posedge clk);
        if (cv) begin
            if (cleared_ok) m_pend[cr] = 1'b0;
            else m_err = 1'b1;
        end
        if (exp_fire && il && rw && rd != 0) m_pend[rd] = 1'b1;
        #1;
        chk({tag, ".pvec"}, pending_vec, m_vec());
        chk({tag, ".outs"}, 32'(outstanding), 32'(m_count()));
        chk({tag, ".err"},  32'(sb_err), 32'(m_err));
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic long_op(input string tag, input logic [4:0] rd);
        step(tag, 1, 1, 1, rd, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic complete(input string tag, input logic [4:0] cr);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, cr);
    endtask

    task automatic reset_check(input string tag);
        rst_n = 1'b0;
        issue_valid = 1'b1; issue_long = $urandom; issue_regwrite = $urandom;
        issue_rd = 5'($urandom); rs1_id = 5'($urandom); rs2_id = 5'($urandom);
        rs1_used = $urandom; rs2_used = $urandom; flush = 1'b0;
        complete_valid = $urandom; complete_rd = 5'($urandom);
        #1;
        m_reset();
        chk({tag, ".pvec"},  pending_vec, 32'd0);
        chk({tag, ".outs"},  32'(outstanding), 32'd0);
        chk({tag, ".err"},   32'(sb_err), 32'd0);
        chk({tag, ".stall"}, 32'(stall_id), 32'd0);
        chk({tag, ".fire"},  32'(issue_fire), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        reset_check("rst0");

        // Load-use: dependent waits until x5 completes
        long_op("lu_issue", 5);
        step("lu_dep0", 1, 0, 1, 8, 5, 1, 0, 0, 0, 0, 0);
        step("lu_dep1", 1, 0, 1, 8, 5, 1, 0, 0, 0, 0, 0);
        step("lu_cmpl", 1, 0, 1, 8, 5, 1, 0, 0, 0, 1, 5);
        step("lu_after", 1, 0, 1, 8, 5, 1, 0, 0, 0, 0, 0);

        // WAW on x7 and x0 destination
        long_op("waw_a", 7);
        long_op("waw_b", 7);
        long_op("x0_long", 0);
        step("rs2_dep", 1, 0, 1, 9, 0, 0, 7, 1, 0, 0, 0);
        complete("waw_done", 7);

        // Structural: fill to MAX_OUT then try a fifth
        long_op("st1", 1); long_op("st2", 2); long_op("st3", 3); long_op("st4", 4);
        long_op("st5_blk", 10);
        step("st5_cmpl", 1, 1, 1, 10, 0, 0, 0, 0, 0, 1, 2);
        idle("st_idle");

        // Error path: x9 not pending, x0 completion; then a valid completion
        complete("err_x9", 9);
        complete("err_x0", 0);
        complete("err_ok", 1);
        idle("err_sticky");

        // Flush: presented long op dropped, prior pending register survives
        long_op("fl_x6", 6);
        step("fl_x3", 1, 1, 1, 3, 0, 0, 0, 0, 1, 0, 0);
        step("fl_dep6", 1, 0, 0, 0, 6, 1, 0, 0, 1, 0, 0);
        idle("fl_idle");

        // Mid-run async reset discards tracking
        reset_check("rst_mid");

        // Random traffic on a small register window to provoke hazards
        for (int n = 0; n < 400; n++) begin
            logic [4:0] rd, r1, r2, cr;
            bit cv;
            rd = 5'($urandom_range(0, 9));
            r1 = 5'($urandom_range(0, 9));
            r2 = 5'($urandom_range(0, 9));
            cv = ($urandom_range(0, 99) < 40);
            cr = 5'($urandom_range(0, 9));
            if (cv && $urandom_range(0, 99) < 85)
                for (int k = 0; k < 10; k++) if (m_pend[(int'(cr) + k) % 10]) begin
                    cr = 5'((int'(cr) + k) % 10);
                    break;
                end
            step("rnd", $urandom_range(0, 99) < 80, $urandom, $urandom_range(0, 99) < 90, rd,
                 r1, $urandom, r2, $urandom, $urandom_range(0, 99) < 10, cv, cr);
            if (n == 200) reset_check("rst_rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
